// File: rtl/register_file.sv
// 32-entry general-purpose register file: two combinational read ports and one write-back port.
// Entry 0 is hardwired to zero. A same-cycle write is bypassed to the read ports.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Entry 0 has no storage, so the array starts at index 1.
  logic [DATA_W-1:0] regs_q [1:DEPTH-1];
  logic [DATA_W-1:0] regs_d [1:DEPTH-1];

  logic              wr_commit;
  logic              bypass_ok;
  logic [DATA_W-1:0] rs_stored;
  logic [DATA_W-1:0] rt_stored;

  assign wr_commit = wr_en && !rst && (wr_addr != '0);
  assign bypass_ok = wr_en && !rst;

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
    end else if (wr_commit) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          regs_d[i] = wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    rs_stored = '0;
    rt_stored = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (rs_addr == ADDR_W'(i)) begin
        rs_stored = regs_q[i];
      end
      if (rt_addr == ADDR_W'(i)) begin
        rt_stored = regs_q[i];
      end
    end
  end

  // Priority per port: zero index, then same-cycle write bypass, then storage.
  always_comb begin
    rs_data = rs_stored;
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (bypass_ok && (wr_addr == rs_addr)) begin
      rs_data = wr_data;
    end
  end

  always_comb begin
    rt_data = rt_stored;
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (bypass_ok && (wr_addr == rt_addr)) begin
      rt_data = wr_data;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file: one vector per clock cycle,
// plus hand-written fill/readback and reset sweeps over every index.
module tb_register_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string             name;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] exp_rs;
    logic [DATA_W-1:0] exp_rt;
  } vec_t;

  vec_t vecs[$];
  logic [DATA_W-1:0] model [0:31];

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input string name, input logic r, input logic we,
                        input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                        input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb);
    vec_t v;
    v.name = name; v.rst = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.rs_addr = ra; v.rt_addr = rb; v.exp_rs = ea; v.exp_rt = eb;
    vecs.push_back(v);
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic applyStimulus(input logic r, input logic we,
                               input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                               input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
    @(posedge clk);
    #1;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rs_addr = ra; rt_addr = rb;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rs_addr = '0; rt_addr = '0;

    //     name             rst we  wa  wd            ra  rb  exp_rs        exp_rt
    addVec("pre_reset_r0",  1, 0,  0, 32'h0,        0,  0, 32'h0,        32'h0);
    addVec("reset_state",   0, 0,  0, 32'h0,        5, 31, 32'h0,        32'h0);
    addVec("wr_r5_bypass",  0, 1,  5, 32'hDEADBEEF, 5,  0, 32'hDEADBEEF, 32'h0);
    addVec("rst_shows_r5",  1, 0,  0, 32'h0,        5,  5, 32'hDEADBEEF, 32'hDEADBEEF);
    addVec("r5_cleared",    0, 0,  0, 32'h0,        5,  5, 32'h0,        32'h0);
    addVec("wr_r1",         0, 1,  1, 32'h12345678, 1, 31, 32'h12345678, 32'h0);
    addVec("wr_r31",        0, 1, 31, 32'hA5A5A5A5, 1, 31, 32'h12345678, 32'hA5A5A5A5);
    addVec("rd_r1_r31",     0, 0,  0, 32'h0,        1, 31, 32'h12345678, 32'hA5A5A5A5);
    addVec("wr_r0_same",    0, 1,  0, 32'hFFFFFFFF, 0,  0, 32'h0,        32'h0);
    addVec("wr_r0_next",    0, 0,  0, 32'h0,        0,  0, 32'h0,        32'h0);
    addVec("wr_r7_init",    0, 1,  7, 32'h11111111, 7,  1, 32'h11111111, 32'h12345678);
    addVec("r7_bypass",     0, 1,  7, 32'h22222222, 7,  7, 32'h22222222, 32'h22222222);
    addVec("r7_stored",     0, 0,  0, 32'h0,        7,  7, 32'h22222222, 32'h22222222);
    addVec("wr_r3_init",    0, 1,  3, 32'h00000042, 3,  3, 32'h00000042, 32'h00000042);
    addVec("r3_wr_dis",     0, 0,  3, 32'hCAFEBABE, 3,  3, 32'h00000042, 32'h00000042);
    addVec("r3_after",      0, 0,  3, 32'hCAFEBABE, 3,  3, 32'h00000042, 32'h00000042);
    addVec("wr_r4_rd_r3",   0, 1,  4, 32'h44444444, 3,  4, 32'h00000042, 32'h44444444);
    addVec("rd_r3_r4",      0, 0,  0, 32'h0,        3,  4, 32'h00000042, 32'h44444444);
    addVec("wr_r9",         0, 1,  9, 32'h00000099, 9,  9, 32'h00000099, 32'h00000099);
    addVec("rst_vs_wr_r9",  1, 1,  9, 32'h0BADF00D, 9,  9, 32'h00000099, 32'h00000099);
    addVec("r9_cleared",    0, 0,  0, 32'h0,        9,  7, 32'h0,        32'h0);
    addVec("r3_r4_cleared", 0, 0,  0, 32'h0,        3,  4, 32'h0,        32'h0);
    addVec("b2b_r12_a",     0, 1, 12, 32'h00000001,12, 12, 32'h00000001, 32'h00000001);
    addVec("b2b_r12_b",     0, 1, 12, 32'h00000002,12, 12, 32'h00000002, 32'h00000002);
    addVec("b2b_r12_c",     0, 1, 12, 32'h00000003,12,  0, 32'h00000003, 32'h0);
    addVec("b2b_r12_last",  0, 0,  0, 32'h0,       12, 12, 32'h00000003, 32'h00000003);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
                    vecs[i].rs_addr, vecs[i].rt_addr);
      checkOutput({vecs[i].name, ".rs"}, rs_data, vecs[i].exp_rs);
      checkOutput({vecs[i].name, ".rt"}, rt_data, vecs[i].exp_rt);
    end

    // Fill every index with a distinct pattern (index 0 write must be dropped).
    for (int i = 0; i < 32; i++) begin
      model[i] = (i == 0) ? 32'h0 : ((32'h01010101 * i) ^ 32'hF0000000);
      applyStimulus(1'b0, 1'b1, ADDR_W'(i), (32'h01010101 * i) ^ 32'hF0000000,
                    ADDR_W'(i), 5'd0);
      checkOutput($sformatf("fill_bypass_r%0d", i), rs_data, model[i]);
    end

    // Read back on both ports with rt walking in the opposite direction.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, ADDR_W'(i), ADDR_W'(31 - i));
      checkOutput($sformatf("readback_rs_r%0d", i), rs_data, model[i]);
      checkOutput($sformatf("readback_rt_r%0d", 31 - i), rt_data, model[31 - i]);
    end

    // Mid-stream reset: every index must read zero afterwards.
    applyStimulus(1'b1, 1'b1, 5'd20, 32'h5A5A5A5A, 5'd20, 5'd0);
    checkOutput("midrst_no_bypass", rs_data, model[20]);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, ADDR_W'(i), ADDR_W'(i));
      checkOutput($sformatf("postrst_rs_r%0d", i), rs_data, 32'h0);
      checkOutput($sformatf("postrst_rt_r%0d", i), rt_data, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

32-entry, 32-bit general-purpose register file for the pipelined CPU. It sits downstream of the 5-bit write-register select multiplexer, which picks rt or rd. That selected destination index travels down the pipeline and arrives here at write-back, where it is written together with the result data. Two read ports feed the decode stage. An internal write-to-read bypass lets decode observe a same-cycle write-back without an extra forwarding path.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, index width; depth is 2**ADDR_W (32 entries)

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; clears all entries
- rs_addr  input  ADDR_W  read port A index (instruction rs field)
- rt_addr  input  ADDR_W  read port B index (instruction rt field)
- wr_en  input  1  write-back enable (RegWrite from the MEM/WB stage)
- wr_addr  input  ADDR_W  write-back destination; originates from the rt/rd select mux
- wr_data  input  DATA_W  write-back result
- rs_data  output  DATA_W  read data A, combinational
- rt_data  output  DATA_W  read data B, combinational

## Operation
- Storage: entries 1..31 are DATA_W-bit registers. Entry 0 has no storage and always reads 0.
- Write:
  - Committed on a rising edge of clk when rst=0, wr_en=1 and wr_addr≠0.
  - A write to index 0 is discarded silently.
- Reset:
  - On a rising edge with rst=1, every entry 1..31 becomes 0.
  - rst has priority over a simultaneous write; that write is lost.
- Read ports are evaluated independently, in this priority order:
  1. If the address is 0, the output is 0.
  2. Else, if wr_en=1, rst=0 and wr_addr equals the address, the output is wr_data (bypass).
  3. Else, the output is the stored entry.
- Bypass is suppressed while rst=1. During reset the outputs show stored contents, or 0 for index 0.
- Both ports may read the same index. Both then return identical data, including bypassed data.
- No X propagation is allowed: every index 0..31 is defined at all times after the first reset edge.

## Timing
- Write latency: data is committed at the edge where wr_en is sampled.
- Bypass: visible on the read outputs in the same cycle, combinationally from wr_data/wr_addr/wr_en. Consequence for decode:
  - In the cycle a WB writes rN, decode reads the new value.
  - In the following cycle, decode reads it from storage.
- Read path: purely combinational from rs_addr/rt_addr to rs_data/rt_data. There is no read latency and no output register.
- Reset values:
  - After the first rst edge, all entries are 0, so rs_data = rt_data = 0 for every address.
  - Before any reset, stored contents are undefined. Index 0 still reads 0.
- Reset asserted mid-stream:
  - Any write presented in a cycle with rst=1 is not committed.
  - The cycle after rst deasserts, all non-zero entries read 0 unless a bypass applies.
- Back-to-back writes to the same index: last write wins. Each intermediate value is visible via bypass in its own cycle.
- No handshake: the block accepts one write per cycle unconditionally. Reads never stall.

## Test plan
- **Reset clear:** write 0xDEADBEEF to r5, assert rst for 1 cycle, read r5 on both ports -> 0x00000000.
- **Write/read back:**
  - Write 0x12345678 to r1, then 0xA5A5A5A5 to r31, on consecutive cycles.
  - Next cycle read rs=r1, rt=r31 -> 0x12345678 / 0xA5A5A5A5.
- **Zero register:**
  - Write 0xFFFFFFFF to r0 with wr_en=1. That same cycle and the next, read r0 on both ports -> 0 both cycles.
  - Bypass must not fire.
- **Same-cycle bypass:**
  - r7 holds 0x11111111. In one cycle drive wr_en=1, wr_addr=7, wr_data=0x22222222, rs=rt=7 -> both outputs 0x22222222 in that cycle.
  - Next cycle with wr_en=0 -> 0x22222222 from storage.
- **Write disabled / mismatched:**
  - wr_en=0, wr_addr=3, wr_data=0xCAFEBABE; r3 holds 0x00000042 -> r3 reads 0x00000042 before and after the edge.
  - With wr_en=1 to r4 while reading r3, rs_data stays 0x00000042.
- **Reset vs write collision:** rst=1 with wr_en=1, wr_addr=9, wr_data=0x0BADF00D -> during that cycle rs=9 shows the stored value, not the bypass; after the edge r9 reads 0.
